// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
//   Definitions shared by the Morse encoder and decoder: FSM state encoding,
//   element encoding, element and space limits, and the eight letter patterns
//   S..Z (codes 0..7).
//
//   Keeping the patterns here means the encoder LUT and the decoder matcher
//   always agree.
//
//   Pattern layout: bits[i] is element i, counting from the first element sent.
//   A set bit means DASH. Bits at positions >= len are always zero.
// -----------------------------------------------------------------------------
package morse_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MARK  = 2'd1;
  localparam logic [1:0] ST_SPACE = 2'd2;

  // Element encoding
  localparam logic ELEM_DOT  = 1'b0;
  localparam logic ELEM_DASH = 1'b1;

  // Maximum number of elements in one letter
  localparam logic [2:0] MAX_ELEM  = 3'd4;
  // Number of space units that ends a letter
  localparam logic [2:0] SPACE_END = 3'd3;
  // Saturation value of the mark run counter
  localparam logic [2:0] RUN_SAT   = 3'd4;

  typedef struct packed {
    logic [2:0] len;   // element count
    logic [3:0] bits;  // element i at bit i, DASH = 1
  } morse_pat_t;

  // Pattern of letter `code`, where 0=S ... 7=Z
  function automatic morse_pat_t letter_pattern(input logic [2:0] code);
    morse_pat_t p;
    case (code)
      3'd0:    p = '{3'd3, 4'b0000};  // S ...
      3'd1:    p = '{3'd1, 4'b0001};  // T -
      3'd2:    p = '{3'd3, 4'b0100};  // U ..-
      3'd3:    p = '{3'd4, 4'b1000};  // V ...-
      3'd4:    p = '{3'd3, 4'b0110};  // W .--
      3'd5:    p = '{3'd4, 4'b1001};  // X -..-
      3'd6:    p = '{3'd4, 4'b1101};  // Y -.--
      default: p = '{3'd4, 4'b0011};  // Z --..
    endcase
    return p;
  endfunction

endpackage

// File: rtl/morse_tick.sv
// -----------------------------------------------------------------------------
// morse_tick
//   A loadable countdown divider. Its `tick` output is high for one cycle
//   when the count reaches 0, and the count then reloads TICK_COUNT.
//   While `run_en` is low, the count holds.
//   `load` has priority over counting and works even while halted.
//
// Parameters
//   TICK_COUNT  reload value (one period = TICK_COUNT+1 cycles)
//   CW          counter width, must hold TICK_COUNT
//
// Ports
//   clk         system clock
//   asr_n       asynchronous active-low reset (count cleared)
//   load        load `load_value` into the count this cycle
//   load_value  value loaded by `load`
//   run_en      1 = count down, 0 = halt
//   tick        one-cycle pulse at count 0 while running
// -----------------------------------------------------------------------------
module morse_tick #(
  parameter int unsigned TICK_COUNT = 24999999,
  parameter int unsigned CW         = 25
) (
  input  logic          clk,
  input  logic          asr_n,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  input  logic          run_en,
  output logic          tick
);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  assign tick = run_en && (count_reg == '0);

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_value;
    end else if (run_en) begin
      if (count_reg == '0) begin
        count_next = CW'(TICK_COUNT);
      end else begin
        count_next = count_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge asr_n) begin
    if (!asr_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/morse_decoder.sv
// -----------------------------------------------------------------------------
// morse_decoder
//   Receiver for a single-wire Morse stream with an active-high mark and one
//   unit per divider period. It samples `din` in the middle of each unit,
//   classifies runs into dots and dashes, and matches the finished letter
//   against S..Z (codes 0..7).
//
// Parameters
//   TICK_COUNT  divider reload; one unit = TICK_COUNT+1 clk cycles (min 3)
//   CW          divider width, must hold TICK_COUNT
//
// Ports
//   clk     system clock
//   asr_n   asynchronous active-low reset
//   din     Morse line, 1 = mark
//   letter  decoded code, held until the next valid
//   valid   one-cycle pulse; letter is updated the same cycle
//   err     one-cycle pulse for a malformed or unknown letter
//   busy    high whenever the FSM is not idle
//
// Build option
//   MORSE_DEC_SYNC_EN  when defined, din goes through a 2-flop synchronizer
//                      (reset to 0) before any logic. All timing shifts by
//                      2 cycles. Use this for buttons or other asynchronous
//                      sources.
// -----------------------------------------------------------------------------
module morse_decoder
  import morse_pkg::*;
#(
  parameter int unsigned TICK_COUNT = 24999999,
  parameter int unsigned CW         = 25
) (
  input  logic       clk,
  input  logic       asr_n,
  input  logic       din,
  output logic [2:0] letter,
  output logic       valid,
  output logic       err,
  output logic       busy
);

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic din_s;

`ifdef MORSE_DEC_SYNC_EN
  logic [1:0] sync_reg;

  always_ff @(posedge clk or negedge asr_n) begin
    if (!asr_n) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], din};
    end
  end

  assign din_s = sync_reg[1];
`else
  assign din_s = din;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0] state_reg,   state_next;
  logic [2:0] run_reg,     run_next;      // units in the current mark/space
  logic [3:0] elem_reg,    elem_next;     // element buffer, first at bit 0
  logic [2:0] cnt_reg,     cnt_next;      // elements buffered
  logic       errflag_reg, errflag_next;
  logic [2:0] letter_reg,  letter_next;
  logic       valid_reg,   valid_next;
  logic       err_reg,     err_next;

  // ---------------------------------------------------------------------------
  // Unit divider
  // ---------------------------------------------------------------------------
  logic tick;
  logic div_load;
  logic div_run;

  // The divider is halted in IDLE. When a letter starts, it is loaded with
  // half a unit, so every later tick lands in the middle of a unit.
  assign div_run = (state_reg != ST_IDLE);

  morse_tick #(
    .TICK_COUNT (TICK_COUNT),
    .CW         (CW)
  ) u_tick (
    .clk        (clk),
    .asr_n      (asr_n),
    .load       (div_load),
    .load_value (CW'(TICK_COUNT >> 1)),
    .run_en     (div_run),
    .tick       (tick)
  );

  // ---------------------------------------------------------------------------
  // Pattern match
  // Buffer positions at or beyond cnt_reg are always zero, as are the unused
  // pattern bits. So a match needs only count equality and whole-buffer
  // equality.
  // ---------------------------------------------------------------------------
  logic [7:0] hit;
  logic       match_hit;
  logic [2:0] match_code;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_match
      morse_pat_t pat_w;
      assign pat_w   = letter_pattern(3'(gi));
      assign hit[gi] = (cnt_reg == pat_w.len) && (elem_reg == pat_w.bits);
    end
  endgenerate

  // The patterns are distinct, so at most one hit is set.
  always_comb begin
    match_code = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (hit[i]) begin
        match_code = 3'(i);
      end
    end
  end

  assign match_hit = |hit;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    run_next     = run_reg;
    elem_next    = elem_reg;
    cnt_next     = cnt_reg;
    errflag_next = errflag_reg;
    letter_next  = letter_reg;
    valid_next   = 1'b0;
    err_next     = 1'b0;
    div_load     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (din_s) begin
          div_load   = 1'b1;
          run_next   = 3'd0;
          state_next = ST_MARK;
        end
      end

      ST_MARK: begin
        if (tick) begin
          if (din_s) begin
            if (run_reg < RUN_SAT) begin
              run_next = run_reg + 3'd1;
            end
          end else if ((run_reg == 3'd0) && (cnt_reg == 3'd0)) begin
            // The mark was shorter than half a unit and nothing is buffered,
            // so treat it as line noise.
            run_next   = 3'd0;
            state_next = ST_IDLE;
          end else begin
            if ((run_reg == 3'd1) || (run_reg == 3'd3)) begin
              if (cnt_reg < MAX_ELEM) begin
                elem_next[cnt_reg[1:0]] = (run_reg == 3'd3) ? ELEM_DASH : ELEM_DOT;
                cnt_next                = cnt_reg + 3'd1;
              end else begin
                errflag_next = 1'b1;
              end
            end else begin
              errflag_next = 1'b1;
            end
            // The sample that ended the mark is the first space unit.
            run_next   = 3'd1;
            state_next = ST_SPACE;
          end
        end
      end

      ST_SPACE: begin
        if (tick) begin
          if (din_s) begin
            // A 2-unit gap is neither an element gap nor a letter gap. It is
            // recorded here and reported when the letter ends.
            if (run_reg == 3'd2) begin
              errflag_next = 1'b1;
            end
            run_next   = 3'd1;
            state_next = ST_MARK;
          end else if ((run_reg + 3'd1) == SPACE_END) begin
            if (!errflag_reg && match_hit) begin
              valid_next  = 1'b1;
              letter_next = match_code;
            end else begin
              err_next = 1'b1;
            end
            elem_next    = 4'd0;
            cnt_next     = 3'd0;
            errflag_next = 1'b0;
            run_next     = 3'd0;
            state_next   = ST_IDLE;
          end else begin
            run_next = run_reg + 3'd1;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge asr_n) begin
    if (!asr_n) begin
      state_reg   <= ST_IDLE;
      run_reg     <= 3'd0;
      elem_reg    <= 4'd0;
      cnt_reg     <= 3'd0;
      errflag_reg <= 1'b0;
      letter_reg  <= 3'd0;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      run_reg     <= run_next;
      elem_reg    <= elem_next;
      cnt_reg     <= cnt_next;
      errflag_reg <= errflag_next;
      letter_reg  <= letter_next;
      valid_reg   <= valid_next;
      err_reg     <= err_next;
    end
  end

  assign letter = letter_reg;
  assign valid  = valid_reg;
  assign err    = err_reg;
  assign busy   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// -----------------------------------------------------------------------------
// tb_morse_decoder
//   Self-checking bench for morse_decoder with TICK_COUNT=3 (unit = 4 cycles).
//   Letters are driven one unit at a time as lists of mark lengths and gap
//   lengths. The expected outcome comes from the Morse rules, using
//   dot/dash strings compared against the S..Z table.
// -----------------------------------------------------------------------------
module tb_morse_decoder;

  localparam int TC   = 3;
  localparam int UNIT = TC + 1;
  localparam int HALF = (TC >> 1) + 1;   // cycles from line edge to first sample
`ifdef MORSE_DEC_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  // Counted from the cycle the line drops after the last mark:
  // half a unit to the first space sample, two more unit samples,
  // and one cycle for the registered pulse.
  localparam int LAT = HALF + 2 * UNIT + 1 + SYNC_LAT;

  logic       clk   = 1'b0;
  logic       asr_n = 1'b0;
  logic       din   = 1'b0;
  logic [2:0] letter;
  logic       valid;
  logic       err;
  logic       busy;

  morse_decoder #(
    .TICK_COUNT (TC),
    .CW         (4)
  ) dut (
    .clk    (clk),
    .asr_n  (asr_n),
    .din    (din),
    .letter (letter),
    .valid  (valid),
    .err    (err),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Pulse monitor
  // ---------------------------------------------------------------------------
  typedef struct {
    bit v;
    bit e;
    int l;
    int c;
  } ev_t;

  ev_t evq[$];

  always @(negedge clk) begin
    if (valid === 1'b1 || err === 1'b1) begin
      ev_t ev;
      ev.v = valid;
      ev.e = err;
      ev.l = int'(letter);
      ev.c = cyc;
      evq.push_back(ev);
      if (valid === 1'b1 && err === 1'b1) check_val("valid_err_exclusive", 32'd1, 32'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  string codes[8] = '{"...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
  int    last_letter = 0;

  task automatic model(input int marks[$], input int gaps[$], output bit ok, output int code);
    string s;
    s    = "";
    ok   = 1'b1;
    code = -1;
    foreach (marks[i]) begin
      if (marks[i] == 1)      s = {s, "."};
      else if (marks[i] == 3) s = {s, "-"};
      else                    ok = 1'b0;
    end
    foreach (gaps[i]) if (gaps[i] != 1) ok = 1'b0;
    if (marks.size() > 4) ok = 1'b0;
    if (ok) begin
      for (int c = 0; c < 8; c++) if (s == codes[c]) code = c;
      if (code < 0) ok = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic drive_unit(input bit b);
    din = b;
    repeat (UNIT) @(negedge clk);
  endtask

  task automatic send_letter(input string name, input int marks[$], input int gaps[$]);
    bit ok;
    int code;
    int fall_cyc;
    int nz;
    model(marks, gaps, ok, code);
    evq.delete();
    foreach (marks[i]) begin
      repeat (marks[i]) drive_unit(1'b1);
      if (i == 0) begin
        check_val({name, "_busy_mid"}, busy, 1);
        check_val({name, "_letter_hold"}, letter, last_letter);
      end
      if (i < gaps.size()) repeat (gaps[i]) drive_unit(1'b0);
    end
    fall_cyc = cyc;
    nz = 4 + $urandom_range(0, 1);
    repeat (nz) drive_unit(1'b0);
    check_val({name, "_n_pulses"}, evq.size(), 1);
    if (evq.size() >= 1) begin
      check_val({name, "_valid"}, evq[0].v, ok);
      check_val({name, "_err"}, evq[0].e, !ok);
      check_val({name, "_latency"}, evq[0].c - fall_cyc, LAT);
      if (ok) last_letter = code;
      check_val({name, "_letter_at_pulse"}, evq[0].l, last_letter);
    end
    check_val({name, "_busy_end"}, busy, 0);
    check_val({name, "_letter_end"}, letter, last_letter);
    $display("letter %-8s marks=%0d exp_%s code=%0d got_pulses=%0d letter=%0d",
             name, marks.size(), ok ? "valid" : "err", last_letter, evq.size(), letter);
    evq.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int m[$];
    int g[$];
    string s;

    // Reset held with the line toggling
    repeat (6) begin
      @(negedge clk);
      din = ~din;
      check_val("rst_letter", letter, 0);
      check_val("rst_valid", valid, 0);
      check_val("rst_err", err, 0);
      check_val("rst_busy", busy, 0);
    end
    din = 1'b0;
    @(negedge clk);
    asr_n = 1'b1;
    repeat (2 * UNIT) @(negedge clk);
    check_val("post_rst_busy", busy, 0);
    check_val("post_rst_pulses", evq.size(), 0);
    $display("reset done letter=%0d busy=%0d", letter, busy);

    // Directed letters
    send_letter("S",      '{1, 1, 1},       '{1, 1});
    send_letter("Y",      '{3, 1, 3, 3},    '{1, 1, 1});
    send_letter("T",      '{3},             '{});
    send_letter("mark2",  '{2},             '{});
    send_letter("5dots",  '{1, 1, 1, 1, 1}, '{1, 1, 1, 1});
    send_letter("S",      '{1, 1, 1},       '{1, 1});
    send_letter("gap2",   '{1, 1},          '{2});
    send_letter("long",   '{6},             '{});

    // Reset during X (-..-): abandon after "-."
    evq.delete();
    drive_unit(1'b1); drive_unit(1'b1); drive_unit(1'b1);
    drive_unit(1'b0); drive_unit(1'b1);
    asr_n = 1'b0;
    #1;
    check_val("midrst_busy", busy, 0);
    check_val("midrst_letter", letter, 0);
    last_letter = 0;
    din = 1'b0;
    repeat (3) @(negedge clk);
    asr_n = 1'b1;
    repeat (5 * UNIT) @(negedge clk);
    check_val("midrst_no_pulse", evq.size(), 0);
    $display("mid-letter reset pulses=%0d busy=%0d", evq.size(), busy);
    send_letter("Z",      '{3, 3, 1, 1},    '{1, 1, 1});

    // Random letters: mostly legal, some malformed
    for (int n = 0; n < 40; n++) begin
      m.delete();
      g.delete();
      if ($urandom_range(0, 9) < 7) begin
        int c;
        c = $urandom_range(0, 7);
        s = codes[c];
        for (int k = 0; k < s.len(); k++) begin
          m.push_back((s[k] == "-") ? 3 : 1);
          if (k > 0) g.push_back(1);
        end
      end else begin
        int ne;
        ne = $urandom_range(1, 5);
        for (int k = 0; k < ne; k++) begin
          m.push_back($urandom_range(1, 5));
          if (k > 0) g.push_back(($urandom_range(0, 3) == 0) ? 2 : 1);
        end
      end
      send_letter("rand", m, g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
